timer1_irq: RTL
===============

// Module: timer1_irq
// PURPOSE
//  IO-mapped 32-bit compare/match timer. Owns the timer1 addresses (110..113, 119) and
//  generates interrupt_request for the j1 core, replacing top's constant-zero interrupt reg.
//  The combined read data is ORed into top's io_din. It returns zero when none of its
//  addresses is selected.
// PARAMETERS
//  ADR_CNTL  16'd110  IO address, counter low half
//  ADR_CNTH  16'd111  IO address, counter high half
//  ADR_CMPL  16'd112  IO address, compare low half
//  ADR_CMPH  16'd113  IO address, compare high half
//  ADR_CTRL  16'd119  IO address, control/status
// PORTS
//  clk                input   1   system clock (oscillator domain)
//  reset              input   1   synchronous, active-high reset
//  io_wr              input   1   IO write strobe from j1, one cycle per access
//  io_rd              input   1   IO read strobe from j1, one cycle per access
//  mem_addr           input   16  IO address from j1
//  dout               input   16  IO write data from j1
//  io_din_t1          output  16  read data; 0 when mem_addr is not one of its addresses
//  interrupt_request  output  1   level interrupt to j1
// BEHAVIOUR
//  Registers: cnt[31:0], cmp[31:0], ctrl = {PRESC[7:0], 4'b0, ONESHOT, PEND, IE, EN},
//   shadow_rd[15:0], stage_cnt[15:0], stage_cmp[15:0], pre[7:0].
//  Reset (sync, high): all registers = 0. Consequences:
//   - interrupt_request = 0 and io_din_t1 = 0 on the cycle after reset is sampled.
//   - Reset mid-count aborts the count with no stale PEND.
//  Prescaler: while EN=1, pre counts 0..PRESC. tick = EN & (pre==PRESC); pre wraps to 0 on tick.
//   - PRESC=0 gives a tick every clock.
//   - pre is cleared on any CTRL write and whenever EN=0.
//  Count step on tick:
//   - cnt==cmp: cnt<=0, PEND<=1, and if ONESHOT then EN<=0.
//   - otherwise cnt<=cnt+1 (32-bit, wraps 0xFFFFFFFF->0 with no PEND).
//   - cmp=0 therefore matches on every tick.
//  interrupt_request = PEND & IE, driven combinationally from registers.
//   - It rises in the cycle after the match tick and stays high until PEND is cleared.
//  CTRL write:
//   - EN, IE, ONESHOT and PRESC load from dout.
//   - dout[2]=1 clears PEND. dout[2]=0 leaves PEND unchanged.
//   - If a match sets PEND in the same cycle as a clear, the set wins.
//  Atomic 32-bit write (counter and compare):
//   - A write to the high half goes to stage_cnt / stage_cmp only.
//   - A write to the low half commits {stage, dout} into cnt / cmp in that cycle.
//   - A counter commit overrides any tick in the same cycle.
//  Atomic 32-bit read:
//   - io_din_t1 is combinational on mem_addr, zero latency, matching top's io_din mux.
//   - ADR_CNTL returns cnt[15:0]. On io_rd at ADR_CNTL, shadow_rd <= cnt[31:16] in that cycle.
//   - ADR_CNTH returns shadow_rd, so software reads low first, then high.
//   - ADR_CMPL / ADR_CMPH return cmp halves directly.
//   - ADR_CTRL returns the ctrl register, with PEND live in bit 2.
//  Other addresses: no register changes, io_din_t1 = 0. Writes to unused ctrl bits are ignored
//   and those bits read 0.
// TESTING
//  1. Reset sequence: pulse reset mid-count -> cnt, ctrl, interrupt_request all 0 the next
//     cycle; reads of 110..119 return 0.
//  2. Periodic match: write cmp 113=0,112=4; ctrl=0x0003 -> PEND set every 5 clocks;
//     interrupt_request high from cycle 6; write ctrl=0x0007 -> it drops, reasserts 5 clocks later.
//  3. Prescale and one-shot: cmp=2, ctrl=0x0309 -> match after 12 clocks; EN reads 0 after the
//     match; cnt holds at 0; IE=0 so interrupt_request stays 0.
//  4. Atomic access: write 111=0x1234, 110=0xFFFF with EN=1, PRESC=0, cmp=0xFFFFFFFF ->
//     next tick gives 0x12350000 (carry); read 110 then 111 -> consistent {high,low} pair;
//     a tick between the two reads does not change 111.
//  5. Collisions: counter-low write in the tick cycle -> written value wins; PEND clear in the
//     match cycle -> PEND=1.
//  6. Decode isolation: io_wr/io_rd at 0x1000, 311, 0x2000 -> no register change, io_din_t1=0.

Source files
------------

// File: rtl/timer1_irq.sv
// -----------------------------------------------------------------------------
// timer1_irq
//
// IO-mapped 32-bit compare/match timer for the j1 core. It owns five IO
// addresses (counter low/high, compare low/high, control/status) and raises a
// level interrupt when the counter matches the compare value. Read data is
// zero whenever none of its addresses is on the bus, so it can be ORed into
// the core's io_din.
//
// Ports
//   clk                system clock
//   reset              synchronous, active-high reset
//   io_wr              IO write strobe (one cycle per access)
//   io_rd              IO read strobe (one cycle per access)
//   mem_addr[15:0]     IO address
//   dout[15:0]         IO write data
//   io_din_t1[15:0]    read data, combinational on mem_addr
//   interrupt_request  level interrupt, PEND & IE
//
// Control register layout: {PRESC[7:0], 4'b0, ONESHOT, PEND, IE, EN}
// -----------------------------------------------------------------------------
module timer1_irq #(
    parameter logic [15:0] ADR_CNTL = 16'd110,
    parameter logic [15:0] ADR_CNTH = 16'd111,
    parameter logic [15:0] ADR_CMPL = 16'd112,
    parameter logic [15:0] ADR_CMPH = 16'd113,
    parameter logic [15:0] ADR_CTRL = 16'd119
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_wr,
    input  logic        io_rd,
    input  logic [15:0] mem_addr,
    input  logic [15:0] dout,
    output logic [15:0] io_din_t1,
    output logic        interrupt_request
);

    logic [31:0] r_cnt;
    logic [31:0] r_cmp;
    logic [15:0] r_shadow_rd;
    logic [15:0] r_stage_cnt;
    logic [15:0] r_stage_cmp;
    logic [7:0]  r_pre;
    logic [7:0]  r_presc;
    logic        r_oneshot;
    logic        r_pend;
    logic        r_ie;
    logic        r_en;

    logic w_sel_cntl;
    logic w_sel_cnth;
    logic w_sel_cmpl;
    logic w_sel_cmph;
    logic w_sel_ctrl;
    logic w_wr_cntl;
    logic w_wr_cnth;
    logic w_wr_cmpl;
    logic w_wr_cmph;
    logic w_wr_ctrl;
    logic w_tick;
    logic w_match;
    logic [15:0] w_ctrl_rd;

    assign w_sel_cntl = (mem_addr == ADR_CNTL);
    assign w_sel_cnth = (mem_addr == ADR_CNTH);
    assign w_sel_cmpl = (mem_addr == ADR_CMPL);
    assign w_sel_cmph = (mem_addr == ADR_CMPH);
    assign w_sel_ctrl = (mem_addr == ADR_CTRL);

    assign w_wr_cntl = io_wr & w_sel_cntl;
    assign w_wr_cnth = io_wr & w_sel_cnth;
    assign w_wr_cmpl = io_wr & w_sel_cmpl;
    assign w_wr_cmph = io_wr & w_sel_cmph;
    assign w_wr_ctrl = io_wr & w_sel_ctrl;

    // A tick is one prescaled count step; the match is judged on the
    // register values present before this edge.
    assign w_tick  = r_en & (r_pre == r_presc);
    assign w_match = w_tick & (r_cnt == r_cmp);

    assign w_ctrl_rd = {r_presc, 4'b0000, r_oneshot, r_pend, r_ie, r_en};

    assign interrupt_request = r_pend & r_ie;

    // Prescaler: restarts from zero on any control write or while disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre <= 8'd0;
        end else if (w_wr_ctrl || !r_en) begin
            r_pre <= 8'd0;
        end else if (w_tick) begin
            r_pre <= 8'd0;
        end else begin
            r_pre <= r_pre + 8'd1;
        end
    end

    // Counter: a low-half write commits the staged high half and beats a tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 32'd0;
        end else if (w_wr_cntl) begin
            r_cnt <= {r_stage_cnt, dout};
        end else if (w_match) begin
            r_cnt <= 32'd0;
        end else if (w_tick) begin
            r_cnt <= r_cnt + 32'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Compare register and the high-half staging registers for both words.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmp       <= 32'd0;
            r_stage_cnt <= 16'd0;
            r_stage_cmp <= 16'd0;
        end else begin
            if (w_wr_cnth) begin
                r_stage_cnt <= dout;
            end else begin
                r_stage_cnt <= r_stage_cnt;
            end
            if (w_wr_cmph) begin
                r_stage_cmp <= dout;
            end else begin
                r_stage_cmp <= r_stage_cmp;
            end
            if (w_wr_cmpl) begin
                r_cmp <= {r_stage_cmp, dout};
            end else if (w_wr_cmph) begin
                r_cmp <= r_cmp;
            end else begin
                r_cmp <= r_cmp;
            end
        end
    end

    // Read shadow: reading the low counter half freezes the high half so the
    // following high read forms a consistent pair even if ticks intervene.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow_rd <= 16'd0;
        end else if (io_rd && w_sel_cntl) begin
            r_shadow_rd <= r_cnt[31:16];
        end else begin
            r_shadow_rd <= r_shadow_rd;
        end
    end

    // Control fields. A software write to EN takes priority over the one-shot
    // auto-disable when both land on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en      <= 1'b0;
            r_ie      <= 1'b0;
            r_oneshot <= 1'b0;
            r_presc   <= 8'd0;
        end else if (w_wr_ctrl) begin
            r_en      <= dout[0];
            r_ie      <= dout[1];
            r_oneshot <= dout[3];
            r_presc   <= dout[15:8];
        end else if (w_match && r_oneshot) begin
            r_en      <= 1'b0;
            r_ie      <= r_ie;
            r_oneshot <= r_oneshot;
            r_presc   <= r_presc;
        end else begin
            r_en      <= r_en;
            r_ie      <= r_ie;
            r_oneshot <= r_oneshot;
            r_presc   <= r_presc;
        end
    end

    // Pending flag: a match sets it and wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= 1'b0;
        end else if (w_match) begin
            r_pend <= 1'b1;
        end else if (w_wr_ctrl && dout[2]) begin
            r_pend <= 1'b0;
        end else begin
            r_pend <= r_pend;
        end
    end

    // Read mux: zero-latency, and zero for any address this block does not own.
    always_comb begin
        io_din_t1 = 16'd0;
        case (1'b1)
            w_sel_cntl: io_din_t1 = r_cnt[15:0];
            w_sel_cnth: io_din_t1 = r_shadow_rd;
            w_sel_cmpl: io_din_t1 = r_cmp[15:0];
            w_sel_cmph: io_din_t1 = r_cmp[31:16];
            w_sel_ctrl: io_din_t1 = w_ctrl_rd;
            default:    io_din_t1 = 16'd0;
        endcase
    end

endmodule
